// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared constants and helpers for the MM:SS.CC stopwatch core.
//   - FSM state encoding (3-bit, IDLE = 0)
//   - BCD wrap limits for centiseconds and seconds
//   - packed time record {min, sec, csec}, 24 bits of BCD
//   - BCD helper functions used by the counters and the top
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  localparam int TIME_W = 24;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RUN       = 3'd1;
  localparam logic [2:0] ST_PAUSE     = 3'd2;
  localparam logic [2:0] ST_RUN_LAP   = 3'd3;
  localparam logic [2:0] ST_PAUSE_LAP = 3'd4;

  localparam logic [7:0] CSEC_MAX = 8'h99;
  localparam logic [7:0] SEC_MAX  = 8'h59;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] csec;
  } sw_time_t;

  // Converts a binary value 0..99 to two packed BCD digits {tens, ones}.
  function automatic logic [7:0] bin_to_bcd8(input int unsigned value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((value / 32'd10) % 32'd10);
    ones = 4'(value % 32'd10);
    return {tens, ones};
  endfunction

  // Adds one to a two-digit BCD value; the ones digit rolls 9 -> 0 with a
  // carry into the tens digit. Callers handle the overall wrap limit.
  function automatic logic [7:0] bcd_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value[3:0] >= 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter that counts 00..limit and wraps back to 00.
// Ports:
//   clk, reset_p  : clock, asynchronous active-high reset
//   clr           : synchronous clear to 00 (wins over inc)
//   inc           : advance by one on this clk
//   limit[7:0]    : last value before wrapping, in BCD
//   bcd[7:0]      : registered count {tens, ones}
//   carry         : inc && bcd == limit, drives inc of the next stage
// -----------------------------------------------------------------------------
module bcd_mod_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] limit,
  output logic [7:0] bcd,
  output logic       carry
);

  logic [7:0] bcd_q;
  logic [7:0] bcd_d;
  logic       at_limit_s;

  assign at_limit_s = (bcd_q == limit);

  // Next count: clear, wrap at the limit, BCD increment, or hold.
  always_comb begin
    bcd_d = bcd_q;
    if (clr) begin
      bcd_d = 8'h00;
    end else if (inc) begin
      if (at_limit_s) begin
        bcd_d = 8'h00;
      end else begin
        bcd_d = bcd_inc8(bcd_q);
      end
    end else begin
      bcd_d = bcd_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      bcd_q <= 8'h00;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd   = bcd_q;
  assign carry = inc & at_limit_s;

endmodule

// File: rtl/stopwatch_bcd_core.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd_core
// MM:SS.CC stopwatch driven by a 10 ms tick, with start/stop, lap freeze and
// clear. Count is packed BCD; display feeds the 7-segment scan driver.
// Ports:
//   clk, reset_p          : clock, asynchronous active-high reset
//   tick_10ms             : one-clk pulse per 10 ms (held high = several ticks)
//   btn_start_stop        : one-clk pulse, toggles run/pause (start from IDLE)
//   btn_lap               : one-clk pulse, freezes/unfreezes the display
//   btn_clear             : one-clk pulse, returns to IDLE with zero count
//   disp_min/sec/csec     : BCD {tens, ones}; lap snapshot while lap_active
//   running               : state is RUN or RUN_LAP
//   lap_active            : state is RUN_LAP or PAUSE_LAP
//   wrap_pulse            : one clk high when MIN_LIMIT:59.99 rolls to 00:00.00
// -----------------------------------------------------------------------------
module stopwatch_bcd_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_LIMIT = 59
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       tick_10ms,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_csec,
  output logic       running,
  output logic       lap_active,
  output logic       wrap_pulse
);

  localparam logic [7:0] MIN_LIMIT_BCD = bin_to_bcd8(MIN_LIMIT);

  logic [2:0] state_q;
  logic [2:0] state_d;
  sw_time_t   snap_q;
  sw_time_t   snap_d;
  logic       wrap_q;
  logic       wrap_d;

  sw_time_t   live_s;
  sw_time_t   shown_s;
  logic [7:0] csec_s;
  logic [7:0] sec_s;
  logic [7:0] min_s;
  logic       run_state_s;
  logic       lap_state_s;
  logic       count_en_s;
  logic       csec_carry_s;
  logic       sec_carry_s;
  logic       min_carry_s;
  logic       take_snap_s;

  assign run_state_s = (state_q == ST_RUN) || (state_q == ST_RUN_LAP);
  assign lap_state_s = (state_q == ST_RUN_LAP) || (state_q == ST_PAUSE_LAP);

  // Counting depends only on the registered state, so a tick alongside a stop
  // still counts and a tick alongside a start does not. Clear overrides.
  assign count_en_s = tick_10ms & run_state_s & ~btn_clear;

  bcd_mod_counter u_csec (
    .clk     (clk),
    .reset_p (reset_p),
    .clr     (btn_clear),
    .inc     (count_en_s),
    .limit   (CSEC_MAX),
    .bcd     (csec_s),
    .carry   (csec_carry_s)
  );

  bcd_mod_counter u_sec (
    .clk     (clk),
    .reset_p (reset_p),
    .clr     (btn_clear),
    .inc     (csec_carry_s),
    .limit   (SEC_MAX),
    .bcd     (sec_s),
    .carry   (sec_carry_s)
  );

  bcd_mod_counter u_min (
    .clk     (clk),
    .reset_p (reset_p),
    .clr     (btn_clear),
    .inc     (sec_carry_s),
    .limit   (MIN_LIMIT_BCD),
    .bcd     (min_s),
    .carry   (min_carry_s)
  );

  assign live_s = '{min: min_s, sec: sec_s, csec: csec_s};

  // FSM next state; priority clear > start_stop > lap, losers are dropped.
  always_comb begin
    state_d     = state_q;
    take_snap_s = 1'b0;
    if (btn_clear) begin
      state_d = ST_IDLE;
    end else if (btn_start_stop) begin
      case (state_q)
        ST_IDLE:      state_d = ST_RUN;
        ST_RUN:       state_d = ST_PAUSE;
        ST_PAUSE:     state_d = ST_RUN;
        ST_RUN_LAP:   state_d = ST_PAUSE_LAP;
        ST_PAUSE_LAP: state_d = ST_RUN_LAP;
        default:      state_d = ST_IDLE;
      endcase
    end else if (btn_lap) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          state_d     = ST_RUN_LAP;
          take_snap_s = 1'b1;
        end
        ST_PAUSE: begin
          state_d     = ST_PAUSE_LAP;
          take_snap_s = 1'b1;
        end
        ST_RUN_LAP: begin
          state_d = ST_RUN;
        end
        ST_PAUSE_LAP: begin
          state_d = ST_PAUSE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Snapshot takes the live value as registered, i.e. before this cycle's
  // increment; the wrap flag mirrors the minute stage carry for one clk.
  always_comb begin
    snap_d = snap_q;
    wrap_d = 1'b0;
    if (btn_clear) begin
      snap_d = '0;
      wrap_d = 1'b0;
    end else if (take_snap_s) begin
      snap_d = live_s;
      wrap_d = min_carry_s;
    end else begin
      snap_d = snap_q;
      wrap_d = min_carry_s;
    end
  end

  // State, snapshot and wrap registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      wrap_q  <= wrap_d;
    end
  end

  assign shown_s    = lap_state_s ? snap_q : live_s;
  assign disp_min   = shown_s.min;
  assign disp_sec   = shown_s.sec;
  assign disp_csec  = shown_s.csec;
  assign running    = run_state_s;
  assign lap_active = lap_state_s;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_bcd_core
// Two instances: dut (MIN_LIMIT=59) takes directed and random stimulus,
// dut2 (MIN_LIMIT=2) is run long enough to roll over the minute limit.
// The reference model keeps the count as a plain number of centiseconds and
// the mode as idle/run/lap flags, and is compared with both DUTs each cycle.
// -----------------------------------------------------------------------------
module tb_stopwatch_bcd_core;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       tick, ss, lap, clr;
  logic [7:0] dmin, dsec, dcs;
  logic       run_o, lapa_o, wrap_o;
  logic       tick2, ss2, lap2, clr2;
  logic [7:0] dmin2, dsec2, dcs2;
  logic       run2_o, lapa2_o, wrap2_o;

  always #5 clk = ~clk;

  stopwatch_bcd_core #(.MIN_LIMIT(59)) dut (
    .clk(clk), .reset_p(reset_p), .tick_10ms(tick), .btn_start_stop(ss),
    .btn_lap(lap), .btn_clear(clr), .disp_min(dmin), .disp_sec(dsec),
    .disp_csec(dcs), .running(run_o), .lap_active(lapa_o), .wrap_pulse(wrap_o)
  );

  stopwatch_bcd_core #(.MIN_LIMIT(2)) dut2 (
    .clk(clk), .reset_p(reset_p), .tick_10ms(tick2), .btn_start_stop(ss2),
    .btn_lap(lap2), .btn_clear(clr2), .disp_min(dmin2), .disp_sec(dsec2),
    .disp_csec(dcs2), .running(run2_o), .lap_active(lapa2_o), .wrap_pulse(wrap2_o)
  );

  typedef struct {
    bit idle;
    bit run;
    bit lap;
    int cnt;
    int snap;
    bit wrap;
  } mdl_t;

  mdl_t m [2];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.idle = 1'b1; r.run = 1'b0; r.lap = 1'b0;
    r.cnt = 0; r.snap = 0; r.wrap = 1'b0;
    return r;
  endfunction

  // One clock of the stopwatch rules, count kept in centiseconds.
  function automatic mdl_t mdl_step(mdl_t s, int limit, bit t, bit st, bit lp, bit cl);
    mdl_t r;
    int   period;
    r = s;
    period = (limit + 1) * 6000;
    if (cl) return mdl_reset();
    r.wrap = 1'b0;
    if (t && s.run) begin
      r.cnt  = (s.cnt + 1) % period;
      r.wrap = (r.cnt == 0);
    end
    if (st) begin
      if (s.idle) begin
        r.idle = 1'b0;
        r.run  = 1'b1;
      end else begin
        r.run = !s.run;
      end
    end else if (lp && !s.idle) begin
      if (!s.lap) r.snap = s.cnt;
      r.lap = !s.lap;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd8(int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [26:0] expected(mdl_t s);
    int v;
    v = s.lap ? s.snap : s.cnt;
    return {bcd8(v / 6000), bcd8((v / 100) % 60), bcd8(v % 100), s.run, s.lap, s.wrap};
  endfunction

  task automatic cmp(input int idx, input logic [26:0] act);
    logic [26:0] req;
    req = expected(m[idx]);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL model_cmp dut%0d t=%0t: got disp %h flags %b, want disp %h flags %b",
               idx, $time, act[26:3], act[2:0], req[26:3], req[2:0]);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, {dmin, dsec, dcs, run_o, lapa_o, wrap_o});
      cmp(1, {dmin2, dsec2, dcs2, run2_o, lapa2_o, wrap2_o});
    end
  end

  task automatic expect_lit(input string name, input int idx, input logic [7:0] mn,
                            input logic [7:0] sc, input logic [7:0] cs,
                            input logic rn, input logic la, input logic wr);
    logic [26:0] act;
    logic [26:0] req;
    act = (idx == 0) ? {dmin, dsec, dcs, run_o, lapa_o, wrap_o}
                     : {dmin2, dsec2, dcs2, run2_o, lapa2_o, wrap2_o};
    req = {mn, sc, cs, rn, la, wr};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %h:%h.%h run=%b lap=%b wrap=%b, want %h:%h.%h run=%b lap=%b wrap=%b",
               name, idx, act[26:19], act[18:11], act[10:3], act[2], act[1], act[0],
               mn, sc, cs, rn, la, wr);
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    if (reset_p) begin
      m[0] = mdl_reset();
      m[1] = mdl_reset();
    end else begin
      m[0] = mdl_step(m[0], 59, tick, ss, lap, clr);
      m[1] = mdl_step(m[1], 2, tick2, ss2, lap2, clr2);
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit t, input bit s, input bit l, input bit c);
    tick = t; ss = s; lap = l; clr = c;
    clk_cycle();
    tick = 1'b0; ss = 1'b0; lap = 1'b0; clr = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_p = 1'b1;
    tick = 1'b0; ss = 1'b0; lap = 1'b0; clr = 1'b0;
    tick2 = 1'b0; ss2 = 1'b0; lap2 = 1'b0; clr2 = 1'b0;
    m[0] = mdl_reset();
    m[1] = mdl_reset();
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    expect_lit("reset", 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    reset_p = 1'b0;

    // Start and count 150 ticks.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(150);
    expect_lit("run_150", 0, 8'h00, 8'h01, 8'h50, 1'b1, 1'b0, 1'b0);

    // Lap freeze and release.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1234);
    expect_lit("run_1234", 0, 8'h00, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(100);
    expect_lit("lap_frozen", 0, 8'h00, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    expect_lit("lap_release", 0, 8'h00, 8'h13, 8'h34, 1'b1, 1'b0, 1'b0);

    // Stop holds the count, restart resumes.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(500);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(50);
    expect_lit("paused_hold", 0, 8'h00, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    expect_lit("resume_1", 0, 8'h00, 8'h05, 8'h01, 1'b1, 1'b0, 1'b0);

    // Coincident tick + stop in RUN is counted.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    expect_lit("tick_stop", 0, 8'h00, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0);

    // Coincident tick + start from IDLE is not counted.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    expect_lit("tick_start", 0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    // Clear + lap in RUN_LAP: clear wins.
    ticks(30);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    expect_lit("clear_lap", 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    expect_lit("idle_lap_ignored", 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Random button and tick traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) == 0));
    end

    // Long run: dut2 wraps 02:59.99 -> 00:00.00, dut reaches 03:21.07.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    ss = 1'b1; ss2 = 1'b1;
    clk_cycle();
    ss = 1'b0; ss2 = 1'b0;
    for (int i = 1; i <= 20107; i++) begin
      tick = 1'b1; tick2 = 1'b1;
      clk_cycle();
      if (i == 17999) expect_lit("pre_wrap", 1, 8'h02, 8'h59, 8'h99, 1'b1, 1'b0, 1'b0);
      if (i == 18000) expect_lit("wrap", 1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
      if (i == 18001) expect_lit("post_wrap", 1, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    end
    tick = 1'b0; tick2 = 1'b0;
    expect_lit("run_32107", 0, 8'h03, 8'h21, 8'h07, 1'b1, 1'b0, 1'b0);
    expect_lit("dut2_after_wrap", 1, 8'h00, 8'h21, 8'h07, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-run clears before the next edge.
    #2;
    reset_p = 1'b1;
    m[0] = mdl_reset();
    m[1] = mdl_reset();
    #1;
    expect_lit("async_reset", 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_lit("async_reset2", 1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    clk_cycle();
    reset_p = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1; tick2 = 1'b1;
      clk_cycle();
    end
    tick = 1'b0; tick2 = 1'b0;
    expect_lit("no_start_after_reset", 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_core.md
Name: stopwatch_bcd_core

Overview:
Stopwatch timekeeping core that consumes the single-cycle 10 ms tick from the clock divider chain (100 MHz -> 1 us -> 1 ms -> 10 ms pulses). It keeps an MM:SS.CC count in packed BCD and handles start/stop, lap freeze and clear. Its display outputs feed the FND/7-segment scan driver downstream.

Parameters:
MIN_LIMIT, 59, largest minutes value before wrap (BCD-decoded, 1..99)

Ports:
clk  input  1  system clock
reset_p  input  1  asynchronous active-high reset
tick_10ms  input  1  one-clk pulse every 10 ms from the divider chain
btn_start_stop  input  1  one-clk pulse (already debounced and edge-detected)
btn_lap  input  1  one-clk pulse (already debounced and edge-detected)
btn_clear  input  1  one-clk pulse (already debounced and edge-detected)
disp_min  output  8  BCD minutes {tens, ones} shown
disp_sec  output  8  BCD seconds {tens, ones} shown
disp_csec  output  8  BCD centiseconds {tens, ones} shown
running  output  1  high in RUN and RUN_LAP
lap_active  output  1  high in RUN_LAP and PAUSE_LAP; display is frozen
wrap_pulse  output  1  one-clk pulse when the count rolls MIN_LIMIT:59.99 -> 00:00.00

Behaviour:
- Interface: reset reset_p is asynchronous and active-high; the clock is clk. All state is on posedge clk.
- Reset: state=IDLE, live count=00:00.00, lap snapshot=00:00.00, all outputs 0.
- States: IDLE, RUN, PAUSE, RUN_LAP, PAUSE_LAP.
- Transitions, with btn_clear evaluated first:
  - btn_clear in any state -> IDLE. Live count and snapshot go to 0 next clk.
  - IDLE: start_stop -> RUN. lap is ignored.
  - RUN: start_stop -> PAUSE. lap -> RUN_LAP and snapshot <= live count.
  - RUN_LAP: start_stop -> PAUSE_LAP. lap -> RUN (display live again).
  - PAUSE: start_stop -> RUN. lap -> PAUSE_LAP and snapshot <= live count.
  - PAUSE_LAP: start_stop -> RUN_LAP. lap -> PAUSE.
- Priority when pulses coincide: clear > start_stop > lap. The lower-priority pulse is dropped, not queued.
- Counting: the live count increments on a clk where tick_10ms=1 and the current registered state is RUN or RUN_LAP.
  - A button in the same cycle does not change this, except clear, which wins and yields 0.
  - A tick that coincides with a start from IDLE/PAUSE is not counted.
  - A tick that coincides with a stop from RUN is counted.
- Snapshot capture takes the live value before that cycle's increment.
- Count is registered; outputs update 1 clk after the tick.
- BCD rules:
  - Each digit is 0-9.
  - csec: 99 -> 00 with carry.
  - sec: 59 -> 00 with carry.
  - min: MIN_LIMIT -> 00 with wrap. wrap_pulse=1 on that same update clk only.
  - Counting continues after a wrap.
  - No digit ever holds A-F.
- Display: disp_* = snapshot when lap_active, else live count. It is a combinational mux of registers; no extra latency.
- running and lap_active are decoded from the registered state.
- Reset asserted mid-run: everything returns to reset values immediately. Counting resumes only after a new start pulse.
- tick_10ms held high for several clks is treated as several ticks; no internal edge detection.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding constants (3-bit, IDLE=0);
  - BCD limits CSEC_MAX=8'h99 and SEC_MAX=8'h59;
  - the snapshot/count record width (24 bits).
- Sub-module bcd_mod_counter, instantiated three times:
  - ports: clk, reset_p, clr, inc, limit[7:0];
  - outputs: bcd[7:0] and carry (1 when inc && bcd==limit);
  - the carry of each stage drives inc of the next.
- The FSM, snapshot register and display mux live in the top.

Test Plan:
1. Reset, start pulse, 150 ticks -> disp = 00:01.50, running=1, lap_active=0, no wrap_pulse.
2. Run to 00:12.34, lap, 100 more ticks -> disp stays 00:12.34 (lap_active=1). Second lap -> disp 00:13.34 live.
3. Run to 00:05.00, stop, 50 ticks -> disp holds 00:05.00, running=0. Start, 1 tick -> 00:05.01.
4. Preload by running to 59:59.99 with MIN_LIMIT=59, 1 tick -> 00:00.00 and wrap_pulse high exactly 1 clk.
   - Repeat with MIN_LIMIT=9: 09:59.99 -> 00:00.00.
5. Coincident stimulus:
   - In RUN at 00:00.10, tick + start_stop in the same clk -> PAUSE, 00:00.11.
   - In IDLE, start + tick -> RUN, 00:00.00.
   - In RUN_LAP, clear + lap -> IDLE, all zero, lap_active=0.
6. Assert reset_p asynchronously mid-RUN at 03:21.07 -> outputs 0 before the next clk edge. After release, 10 ticks without start -> disp stays 00:00.00.
